// File: rtl/bus_arb_pkg.sv
// Shared definitions for the two-master peripheral bus arbiter.
//   BUS_W             : width of the address and data buses
//   IDLE_ADDR_DEFAULT : unmapped address driven when no transaction is active
//   state_e           : arbiter sequencer states
package bus_arb_pkg;

  localparam int unsigned BUS_W = 8;

  localparam logic [BUS_W-1:0] IDLE_ADDR_DEFAULT = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RADDR,
    RCAP,
    DONE
  } state_e;

endpackage

// File: rtl/bus_write_arbiter_rr_pick2.sv
// Combinational two-request round-robin picker.
//   req[1:0]    : request from master 1 / master 0
//   last_grant  : master granted most recently
//   grant_valid : at least one request present
//   grant_id    : chosen master (a tie goes to the master that is not last_grant)
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = 1'b0;
    case (req)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/bus_write_arbiter.sv
// Two-master arbiter and sequencer for the shared 8-bit peripheral bus.
// Each granted request becomes one registered bus transaction:
//   write : IDLE -> WRITE -> DONE
//   read  : IDLE -> RADDR -> RCAP -> DONE (data captured at the end of RCAP)
// Ports:
//   CLK, RESET                 : clock, asynchronous active-high reset
//   Mx_REQ/WE/ADDR/WDATA       : master x request and operands (held until Mx_ACK)
//   Mx_ACK                     : one-cycle completion pulse
//   Mx_RDATA                   : last read result for master x
//   BUS_ADDR, BUS_WE, BUS_DATA : shared peripheral bus (BUS_DATA driven only in WRITE)
//   BUS_BUSY                   : high whenever the sequencer is not IDLE
module bus_write_arbiter
  import bus_arb_pkg::*;
#(
  parameter logic [BUS_W-1:0] IDLE_ADDR = IDLE_ADDR_DEFAULT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             M0_REQ,
  input  logic             M0_WE,
  input  logic [BUS_W-1:0] M0_ADDR,
  input  logic [BUS_W-1:0] M0_WDATA,
  output logic             M0_ACK,
  output logic [BUS_W-1:0] M0_RDATA,
  input  logic             M1_REQ,
  input  logic             M1_WE,
  input  logic [BUS_W-1:0] M1_ADDR,
  input  logic [BUS_W-1:0] M1_WDATA,
  output logic             M1_ACK,
  output logic [BUS_W-1:0] M1_RDATA,
  inout  logic [BUS_W-1:0] BUS_DATA,
  output logic [BUS_W-1:0] BUS_ADDR,
  output logic             BUS_WE,
  output logic             BUS_BUSY
);

  state_e           state_q,      state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q,      owner_d;
  logic             we_lat_q,     we_lat_d;
  logic [BUS_W-1:0] addr_lat_q,   addr_lat_d;
  logic [BUS_W-1:0] wdata_lat_q,  wdata_lat_d;
  logic [BUS_W-1:0] bus_addr_q,   bus_addr_d;
  logic             bus_we_q,     bus_we_d;
  logic             busy_q,       busy_d;
  logic [1:0]       ack_q,        ack_d;
  logic [BUS_W-1:0] rdata0_q,     rdata0_d;
  logic [BUS_W-1:0] rdata1_q,     rdata1_d;

  logic grant_valid;
  logic grant_id;

  rr_pick2 u_pick (
    .req         ({M1_REQ, M0_REQ}),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_lat_d     = we_lat_q;
    addr_lat_d   = addr_lat_q;
    wdata_lat_d  = wdata_lat_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    bus_addr_d   = IDLE_ADDR;
    bus_we_d     = 1'b0;
    ack_d        = '0;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d      = grant_id;
          last_grant_d = grant_id;
          we_lat_d     = grant_id ? M1_WE    : M0_WE;
          addr_lat_d   = grant_id ? M1_ADDR  : M0_ADDR;
          wdata_lat_d  = grant_id ? M1_WDATA : M0_WDATA;
          state_d      = we_lat_d ? WRITE : RADDR;
        end
      end
      WRITE: state_d = DONE;
      RADDR: state_d = RCAP;
      RCAP: begin
        if (owner_q) rdata1_d = BUS_DATA;
        else         rdata0_d = BUS_DATA;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered, so they are decoded from the state being
    // entered rather than the current one.
    case (state_d)
      WRITE: begin
        bus_addr_d = addr_lat_d;
        bus_we_d   = 1'b1;
      end
      RADDR, RCAP: bus_addr_d = addr_lat_d;
      DONE:        ack_d[owner_d] = 1'b1;
      default:     ;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_lat_q     <= 1'b0;
      addr_lat_q   <= '0;
      wdata_lat_q  <= '0;
      bus_addr_q   <= IDLE_ADDR;
      bus_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      ack_q        <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_lat_q     <= we_lat_d;
      addr_lat_q   <= addr_lat_d;
      wdata_lat_q  <= wdata_lat_d;
      bus_addr_q   <= bus_addr_d;
      bus_we_q     <= bus_we_d;
      busy_q       <= busy_d;
      ack_q        <= ack_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // BUS_WE is high exactly in WRITE, so it doubles as the data driver enable.
  assign BUS_DATA = bus_we_q ? wdata_lat_q : 'z;

  assign BUS_ADDR = bus_addr_q;
  assign BUS_WE   = bus_we_q;
  assign BUS_BUSY = busy_q;
  assign M0_ACK   = ack_q[0];
  assign M1_ACK   = ack_q[1];
  assign M0_RDATA = rdata0_q;
  assign M1_RDATA = rdata1_q;

endmodule

// File: tb/tb_bus_write_arbiter.sv
// Self-checking bench for bus_write_arbiter: directed scenarios followed by
// randomized master traffic, checked every cycle against a transaction-level
// reference model (grant rule plus fixed latencies).
`timescale 1ns/1ps
module tb_bus_write_arbiter;

  localparam logic [7:0] KEEP = 8'h3C;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       req   [2];
  logic       we    [2];
  logic [7:0] addr  [2];
  logic [7:0] wdata [2];

  logic       M0_ACK, M1_ACK, BUS_WE, BUS_BUSY;
  logic [7:0] M0_RDATA, M1_RDATA, BUS_ADDR;
  wire  [7:0] BUS_DATA;

  bus_write_arbiter #(.IDLE_ADDR(8'hFF)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .M0_REQ   (req[0]),
    .M0_WE    (we[0]),
    .M0_ADDR  (addr[0]),
    .M0_WDATA (wdata[0]),
    .M0_ACK   (M0_ACK),
    .M0_RDATA (M0_RDATA),
    .M1_REQ   (req[1]),
    .M1_WE    (we[1]),
    .M1_ADDR  (addr[1]),
    .M1_WDATA (wdata[1]),
    .M1_ACK   (M1_ACK),
    .M1_RDATA (M1_RDATA),
    .BUS_DATA (BUS_DATA),
    .BUS_ADDR (BUS_ADDR),
    .BUS_WE   (BUS_WE),
    .BUS_BUSY (BUS_BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] rd_value(input logic [7:0] a);
    return a ^ 8'hFC;
  endfunction

  // Peripheral side: readable registers answer one cycle after the address,
  // a keeper pattern fills every other non-write cycle, LED register at C0.
  logic       per_rd_q   = 1'b0;
  logic [7:0] per_addr_q = 8'hFF;
  logic [7:0] led_q      = 8'h00;
  always @(posedge CLK) begin
    per_rd_q   <= !BUS_WE && (BUS_ADDR != 8'hFF);
    per_addr_q <= BUS_ADDR;
    if (BUS_WE && BUS_ADDR == 8'hC0) led_q <= BUS_DATA;
  end
  assign BUS_DATA = BUS_WE ? 8'hzz : (per_rd_q ? rd_value(per_addr_q) : KEEP);

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: one transaction in flight, tracked by cycles since grant.
  bit         m_act;
  int         m_ph;
  int         m_own;
  int         m_last;
  bit         m_we;
  logic [7:0] m_addr, m_wd;
  logic [7:0] m_rdata [2];
  logic [7:0] e_addr;
  bit         e_we, e_busy;
  bit         e_ack [2];
  bit         p_rd;
  logic [7:0] p_addr;

  task automatic model_reset();
    m_act = 0; m_ph = 0; m_own = 0; m_last = 1;
    m_rdata[0] = 8'h00; m_rdata[1] = 8'h00;
    e_addr = 8'hFF; e_we = 0; e_busy = 0; e_ack[0] = 0; e_ack[1] = 0;
  endtask

  task automatic model_step();
    int ack_ph;
    p_rd   = !e_we && (e_addr != 8'hFF);
    p_addr = e_addr;
    if (RESET) begin
      model_reset();
      return;
    end
    if (m_act) begin
      m_ph++;
      if (m_ph > (m_we ? 1 : 2)) m_act = 0;
    end else if (req[0] || req[1]) begin
      if (req[0] && req[1]) m_own = 1 - m_last;
      else                  m_own = req[1] ? 1 : 0;
      m_last = m_own;
      m_we   = we[m_own];
      m_addr = addr[m_own];
      m_wd   = wdata[m_own];
      m_act  = 1;
      m_ph   = 0;
    end
    e_addr = 8'hFF; e_we = 0; e_busy = m_act; e_ack[0] = 0; e_ack[1] = 0;
    if (m_act) begin
      ack_ph = m_we ? 1 : 2;
      if (m_ph < ack_ph) begin
        e_addr = m_addr;
        e_we   = m_we;
      end else begin
        e_ack[m_own] = 1;
        if (!m_we) m_rdata[m_own] = rd_value(m_addr);
      end
    end
  endtask

  task automatic check_outputs(input string ph);
    logic [7:0] exp_data;
    exp_data = e_we ? m_wd : (p_rd ? rd_value(p_addr) : KEEP);
    check_eq({ph, ".addr"},  BUS_ADDR, e_addr);
    check_eq({ph, ".we"},    BUS_WE,   e_we);
    check_eq({ph, ".busy"},  BUS_BUSY, e_busy);
    check_eq({ph, ".ack0"},  M0_ACK,   e_ack[0]);
    check_eq({ph, ".ack1"},  M1_ACK,   e_ack[1]);
    check_eq({ph, ".rd0"},   M0_RDATA, m_rdata[0]);
    check_eq({ph, ".rd1"},   M1_RDATA, m_rdata[1]);
    check_eq({ph, ".data"},  BUS_DATA, exp_data);
    check_eq({ph, ".ack2"},  M0_ACK && M1_ACK, 0);
  endtask

  int         we_cyc [$];
  logic [7:0] we_dat [$];
  int         ack_log [$];

  task automatic tick(input string ph);
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    cyc++;
    check_outputs(ph);
    if (BUS_WE) begin
      we_cyc.push_back(int'(cyc));
      we_dat.push_back(BUS_DATA);
    end
    if (M0_ACK) ack_log.push_back(0);
    if (M1_ACK) ack_log.push_back(1);
  endtask

  task automatic apply_reset();
    RESET = 1'b1;
    #1;
    model_reset();
    check_outputs("arst");
    tick("rst");
    RESET = 1'b0;
  endtask

  task automatic new_op(input int i);
    req[i]   = 1'b1;
    we[i]    = 1'($urandom_range(1, 0));
    addr[i]  = ($urandom_range(2, 0) == 0) ? 8'hC0 : 8'(8'hA0 + $urandom_range(14, 0));
    wdata[i] = 8'($urandom);
  endtask

  task automatic auto_master();
    logic ack_i;
    for (int i = 0; i < 2; i++) begin
      ack_i = (i == 0) ? M0_ACK : M1_ACK;
      if (ack_i || !req[i]) begin
        if ($urandom_range(3, 0) != 0) new_op(i);
        else                           req[i] = 1'b0;
      end else if (m_act && m_own == i && $urandom_range(1, 0) == 1) begin
        we[i]    = 1'($urandom_range(1, 0));
        addr[i]  = 8'($urandom);
        wdata[i] = 8'($urandom);
      end
    end
  endtask

  initial begin
    int n;
    bit seen;
    RESET = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 8'h00; wdata[i] = 8'h00;
    end
    model_reset();
    p_rd = 0; p_addr = 8'hFF;
    tick("rst");
    tick("rst");
    RESET = 1'b0;
    tick("idle");

    // Single write; operands scrambled during WRITE must not reach the bus.
    we_cyc.delete(); we_dat.delete();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'hC0; wdata[0] = 8'hA5;
    tick("wr");
    addr[0] = 8'hFF; wdata[0] = 8'h00;
    tick("wr");
    req[0] = 1'b0;
    tick("wr");
    check_eq("led", led_q, 8'hA5);
    check_eq("wr_once", we_cyc.size(), 1);

    // Both masters writing back to back: M0, M1, M0, three cycles apart.
    apply_reset();
    we_cyc.delete(); we_dat.delete();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'hC0; wdata[0] = 8'h11;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 8'hC0; wdata[1] = 8'h22;
    repeat (9) tick("alt");
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (2) tick("alt");
    check_eq("alt_n", we_dat.size(), 3);
    if (we_dat.size() == 3) begin
      check_eq("alt_0", we_dat[0], 8'h11);
      check_eq("alt_1", we_dat[1], 8'h22);
      check_eq("alt_2", we_dat[2], 8'h11);
      check_eq("alt_gap1", we_cyc[1] - we_cyc[0], 3);
      check_eq("alt_gap2", we_cyc[2] - we_cyc[1], 3);
    end

    // M1 read of A0; peripheral returns 5C.
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'hA0;
    n = 0; seen = 0;
    while (!seen && n < 8) begin
      tick("rd");
      n++;
      if (M1_ACK) begin
        seen = 1;
        check_eq("rd_data", M1_RDATA, 8'h5C);
      end
    end
    check_eq("rd_lat", n, 3);
    req[1] = 1'b0;
    tick("rd");

    // Reset during RCAP with M1 pending; afterwards M0 must be served first.
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'hA3;
    tick("rcap");
    tick("rcap");
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 8'hC0; wdata[1] = 8'h77;
    apply_reset();
    ack_log.delete();
    n = 0;
    while ((req[0] || req[1]) && n < 20) begin
      tick("post");
      n++;
      if (M0_ACK) req[0] = 1'b0;
      if (M1_ACK) req[1] = 1'b0;
    end
    check_eq("post_n", ack_log.size(), 2);
    if (ack_log.size() == 2) begin
      check_eq("post_first", ack_log[0], 0);
      check_eq("post_second", ack_log[1], 1);
    end

    // REQ held through DONE: one new transaction per IDLE, none from DONE.
    tick("hold");
    we_cyc.delete(); we_dat.delete();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'hC0; wdata[0] = 8'h33;
    repeat (7) tick("hold");
    check_eq("hold_n", we_cyc.size(), 3);
    tick("hold");
    req[0] = 1'b0;
    tick("hold");

    // Randomized traffic from both masters.
    for (int k = 0; k < 800; k++) begin
      auto_master();
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
